uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter, next generation of the fixed 8N1 TX.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tick_counter.sv | 36 +++
 rtl/uart_tx_cfg.sv | 152 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity codes and frame helpers.
// Imported by the TX path and the tick counter reused by the RX path.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Code 11 is reserved and behaves as no parity.
    function automatic logic has_parity(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

    function automatic int unsigned frame_bits(
        input int unsigned data_w,
        input logic [1:0]  par,
        input logic        stop2
    );
        return 1 + data_w + (has_parity(par) ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Counts oversampled baud ticks and flags the tick that closes a bit period.
// The clear input has priority, so a tick arriving in a clear cycle is dropped.
module uart_tick_counter #(
    parameter int OS_RATE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic tick_i,
    output logic bit_end_o
);

    localparam int CW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = tick_i && !clr_i && (cnt_q == CW'(OS_RATE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, optional parity, 1/2 stop.
// Word and configuration are captured at accept and held for the whole frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OS_RATE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              o_tx_busy,
    output logic              o_tx_done,
    output logic              o_tx
);

    localparam int BW = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]        par_cfg_q, par_cfg_d;
    logic              stop2_q, stop2_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_end;

    assign tx_ready  = (state_q == IDLE);
    assign accept    = tx_valid && tx_ready;
    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

    // Held clear while idle so every frame starts its count from zero.
    uart_tick_counter #(
        .OS_RATE (OS_RATE)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tx_ready),
        .tick_i    (baud_tick),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_cfg_d = par_cfg_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    shift_d   = din;
                    par_cfg_d = cfg_parity;
                    stop2_d   = cfg_stop2;
                    par_bit_d = (cfg_parity == PAR_ODD) ? ~^din : ^din;
                    bit_cnt_d = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (has_parity(par_cfg_q)) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BW'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_cfg_q <= PAR_NONE;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_cfg_q <= par_cfg_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DATA_W=8, OS_RATE=16, tick every 4 clk).
// Each frame is sampled mid-bit and compared against hand-computed vectors.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] din = 8'h00;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       o_tx_busy;
    logic       o_tx_done;
    logic       o_tx;

    int errors = 0;
    int checks = 0;
    int tphase = 0;

    logic snap_tx, snap_busy, snap_done, poke_rdy;

    uart_tx_cfg #(
        .DATA_W  (8),
        .OS_RATE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .din        (din),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done),
        .o_tx       (o_tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tphase    = (tphase + 1) % 4;
        baud_tick = (tphase == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] p,
                        input logic s2);
        din        = d;
        cfg_parity = p;
        cfg_stop2  = s2;
        tx_valid   = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Called one step after the accept edge; returns one step after done.
    task automatic capture(input int poke_tick, input int rst_tick,
                           output logic [15:0] bits, output int done_t,
                           output logic busy_ok, output logic rst_hit);
        int t;
        t       = 0;
        bits    = '0;
        done_t  = -1;
        busy_ok = 1'b1;
        rst_hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (baud_tick) begin
                t++;
                if ((t % 16) == 8 && (t / 16) < 16) bits[t/16] = o_tx;
            end
            if (o_tx_done) begin
                done_t = t;
                return;
            end
            if (!o_tx_busy) busy_ok = 1'b0;
            if (baud_tick && t == poke_tick) begin
                din        = 8'hFF;
                cfg_parity = 2'b10;
                tx_valid   = 1'b1;
                poke_rdy   = tx_ready;
                @(posedge clk); #1;
                tx_valid = 1'b0;
            end
            if (baud_tick && t == rst_tick) begin
                reset = 1'b1;
                #1;
                snap_tx   = o_tx;
                snap_busy = o_tx_busy;
                snap_done = o_tx_done;
                rst_hit   = 1'b1;
                return;
            end
        end
    endtask

    logic [15:0] bits;
    int          dt;
    logic        bok, rh, seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_tx_busy, 0);
        chk("rst_done", o_tx_done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", tx_ready, 1);

        send(8'hA5, 2'b00, 1'b0);
        chk("t1_accept_busy", o_tx_busy, 1);
        chk("t1_start_bit", o_tx, 0);
        chk("t1_ready_low", tx_ready, 0);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t1_bits", bits, 16'h034A);
        chk("t1_done_tick", dt, 160);
        chk("t1_busy_held", bok, 1);
        chk("t1_busy_drop", o_tx_busy, 0);

        send(8'h07, 2'b10, 1'b0);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t2_even_bits", bits, 16'h060E);
        chk("t2_even_done", dt, 176);

        send(8'h07, 2'b01, 1'b0);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t2_odd_bits", bits, 16'h040E);
        chk("t2_odd_done", dt, 176);

        send(8'h00, 2'b00, 1'b1);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t3_stop2_bits", bits, 16'h0600);
        chk("t3_stop2_done", dt, 176);

        send(8'hA5, 2'b11, 1'b0);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t3_res_bits", bits, 16'h034A);
        chk("t3_res_done", dt, 160);

        send(8'h3C, 2'b00, 1'b0);
        capture(40, -1, bits, dt, bok, rh);
        chk("t4_poke_ready", poke_rdy, 0);
        chk("t4_bits", bits, 16'h0278);
        chk("t4_done", dt, 160);
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (o_tx_busy || !o_tx) seen = 1'b1;
        end
        chk("t4_no_second", seen, 0);

        send(8'h96, 2'b00, 1'b0);
        capture(-1, 72, bits, dt, bok, rh);
        chk("t5_rst_hit", rh, 1);
        chk("t5_rst_tx", snap_tx, 1);
        chk("t5_rst_busy", snap_busy, 0);
        chk("t5_rst_done", snap_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (o_tx_done || o_tx_busy || !o_tx) seen = 1'b1;
        end
        chk("t5_no_done", seen, 0);
        chk("t5_ready", tx_ready, 1);
        send(8'h55, 2'b00, 1'b0);
        capture(-1, -1, bits, dt, bok, rh);
        chk("t5_clean_bits", bits, 16'h02AA);
        chk("t5_clean_done", dt, 160);

        din        = 8'h81;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        tx_valid   = 1'b1;
        @(posedge clk); #1;
        chk("t6_accept1", o_tx_busy, 1);
        din = 8'h5A;
        capture(-1, -1, bits, dt, bok, rh);
        chk("t6_bits1", bits, 16'h0302);
        chk("t6_done1", dt, 160);
        chk("t6_gap_busy", o_tx_busy, 0);
        chk("t6_gap_ready", tx_ready, 1);
        @(posedge clk); #1;
        chk("t6_rebusy", o_tx_busy, 1);
        chk("t6_start2", o_tx, 0);
        chk("t6_done_pulse", o_tx_done, 0);
        tx_valid = 1'b0;
        capture(-1, -1, bits, dt, bok, rh);
        chk("t6_bits2", bits, 16'h02B4);
        chk("t6_done2", dt, 160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
